// File: rtl/adder_scheduler_pkg.sv
// Shared definitions for the adder scheduler: widths, FSM encoding,
// response latencies and the operand conditioning helper.
package adder_scheduler_pkg;

    localparam int WIDTH    = 32;
    localparam int DW_WIDTH = 2 * WIDTH;

    // Accept cycle to first rsp_valid cycle, in clock cycles.
    localparam int LAT_SW = 2;
    localparam int LAT_DW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Subtraction is A + ~B + 1, so the B operand is inverted for sub.
    function automatic logic [WIDTH-1:0] cond_invert(input logic [WIDTH-1:0] value,
                                                     input logic             invert);
        logic [WIDTH-1:0] result;
        if (invert) begin
            result = ~value;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_scheduler_if.sv
// Request/response bundle between the two requesters, the result consumer
// and the adder scheduler.
interface adder_scheduler_if;
    import adder_scheduler_pkg::*;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [DW_WIDTH-1:0] req0_a;
    logic [DW_WIDTH-1:0] req0_b;
    logic [DW_WIDTH-1:0] req1_a;
    logic [DW_WIDTH-1:0] req1_b;
    logic [1:0]          req_sub;
    logic [1:0]          req_dw;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DW_WIDTH-1:0] rsp_sum;
    logic                rsp_cout;

    // Requester/consumer side.
    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, req_sub, req_dw, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, req_sub, req_dw, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Grants only while enabled; on a contended
// request the requester that did not win last time is chosen.
module adder_scheduler_rr_arbiter2 #(
    parameter logic RR_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic       enable,
    output logic [1:0] grant_s,
    output logic       grant_id_s
);

    logic last_grant_r;

    // Pick the winner among the currently valid requesters.
    always_comb begin
        grant_s    = 2'b00;
        grant_id_s = 1'b0;
        if (enable) begin
            case (req_valid)
                2'b01: begin
                    grant_s    = 2'b01;
                    grant_id_s = 1'b0;
                end
                2'b10: begin
                    grant_s    = 2'b10;
                    grant_id_s = 1'b1;
                end
                2'b11: begin
                    grant_id_s = ~last_grant_r;
                    grant_s    = last_grant_r ? 2'b01 : 2'b10;
                end
                default: begin
                    grant_s    = 2'b00;
                    grant_id_s = 1'b0;
                end
            endcase
        end else begin
            grant_s    = 2'b00;
            grant_id_s = 1'b0;
        end
    end

    // Remember the last winner; reset so that RR_FIRST wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= ~RR_FIRST;
        end else if (|grant_s) begin
            last_grant_r <= grant_id_s;
        end
    end

endmodule

// File: rtl/nbit_adder.sv
// Plain N-bit ripple-carry adder shared by the scheduler.
module nbit_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Ripple the carry bit by bit from cin to cout.
    always_comb begin
        logic carry;
        sum   = '0;
        carry = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one WIDTH-bit ripple adder between two requesters. Single-word
// ops take one adder pass; double-word ops take a low pass and a high pass
// that consumes the registered low carry. Results leave on one
// valid/ready channel tagged with the owning requester.
module adder_scheduler
    import adder_scheduler_pkg::*;
#(
    parameter logic RR_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    adder_scheduler_if.slave sif
);

    state_e              state_r;
    state_e              state_nxt_s;

    logic                arb_enable_s;
    logic [1:0]          grant_s;
    logic                grant_id_s;
    logic                accept_s;

    logic [DW_WIDTH-1:0] op_a_r;
    logic [DW_WIDTH-1:0] op_b_r;
    logic                op_sub_r;
    logic                op_dw_r;
    logic                op_id_r;

    logic [WIDTH-1:0]    add_a_s;
    logic [WIDTH-1:0]    add_b_s;
    logic                add_cin_s;
    logic [WIDTH-1:0]    add_sum_s;
    logic                add_cout_s;

    logic [WIDTH-1:0]    sum_lo_r;
    logic                carry_lo_r;

    logic                rsp_valid_r;
    logic                rsp_id_r;
    logic [DW_WIDTH-1:0] rsp_sum_r;
    logic                rsp_cout_r;

    // Grants are only offered while idle; ready is also held low during reset.
    assign arb_enable_s = (state_r == ST_IDLE) && !reset;

    adder_scheduler_rr_arbiter2 #(
        .RR_FIRST (RR_FIRST)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (sif.req_valid),
        .enable     (arb_enable_s),
        .grant_s    (grant_s),
        .grant_id_s (grant_id_s)
    );

    // A grant is an accept: the requester holds valid until it sees ready.
    assign accept_s      = |grant_s;
    assign sif.req_ready = grant_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_LO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (op_dw_r) begin
                    state_nxt_s = ST_HI;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_HI: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (sif.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the winning requester's operation on the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_r   <= {DW_WIDTH{1'b0}};
            op_b_r   <= {DW_WIDTH{1'b0}};
            op_sub_r <= 1'b0;
            op_dw_r  <= 1'b0;
            op_id_r  <= 1'b0;
        end else if (accept_s) begin
            if (grant_id_s) begin
                op_a_r <= sif.req1_a;
                op_b_r <= sif.req1_b;
            end else begin
                op_a_r <= sif.req0_a;
                op_b_r <= sif.req0_b;
            end
            op_sub_r <= sif.req_sub[grant_id_s];
            op_dw_r  <= sif.req_dw[grant_id_s];
            op_id_r  <= grant_id_s;
        end
    end

    // Steer the low or high word into the adder; the high pass chains the low carry.
    always_comb begin
        add_a_s   = op_a_r[WIDTH-1:0];
        add_b_s   = cond_invert(op_b_r[WIDTH-1:0], op_sub_r);
        add_cin_s = op_sub_r;
        if (state_r == ST_HI) begin
            add_a_s   = op_a_r[DW_WIDTH-1:WIDTH];
            add_b_s   = cond_invert(op_b_r[DW_WIDTH-1:WIDTH], op_sub_r);
            add_cin_s = carry_lo_r;
        end else begin
            add_a_s   = op_a_r[WIDTH-1:0];
            add_b_s   = cond_invert(op_b_r[WIDTH-1:0], op_sub_r);
            add_cin_s = op_sub_r;
        end
    end

    nbit_adder #(
        .N (WIDTH)
    ) u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Hold the low-pass sum and carry for the high pass of a double-word op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_lo_r   <= {WIDTH{1'b0}};
            carry_lo_r <= 1'b0;
        end else if (state_r == ST_LO) begin
            sum_lo_r   <= add_sum_s;
            carry_lo_r <= add_cout_s;
        end
    end

    // Load the response on the last adder pass; hold it until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_sum_r   <= {DW_WIDTH{1'b0}};
            rsp_cout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_LO: begin
                    if (!op_dw_r) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= op_id_r;
                        rsp_sum_r   <= {{WIDTH{1'b0}}, add_sum_s};
                        rsp_cout_r  <= add_cout_s;
                    end
                end
                ST_HI: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= op_id_r;
                    rsp_sum_r   <= {add_sum_s, sum_lo_r};
                    rsp_cout_r  <= add_cout_s;
                end
                ST_RESP: begin
                    if (sif.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= rsp_valid_r;
                end
            endcase
        end
    end

    assign sif.rsp_valid = rsp_valid_r;
    assign sif.rsp_id    = rsp_id_r;
    assign sif.rsp_sum   = rsp_sum_r;
    assign sif.rsp_cout  = rsp_cout_r;

endmodule

// File: tb/tb_adder_scheduler.sv
// Bench for adder_scheduler: directed cases with literal results, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_adder_scheduler;
    import adder_scheduler_pkg::*;

    localparam logic RR_FIRST = 1'b0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    adder_scheduler_if sif();

    adder_scheduler #(.RR_FIRST(RR_FIRST)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of an operation straight from arithmetic.
    function automatic void golden(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input logic d,
                                   output logic [63:0] sum, output logic cout);
        logic [64:0] t;
        logic [32:0] t32;
        if (d) begin
            if (s) begin
                sum  = a - b;
                cout = (a >= b);
            end else begin
                t    = {1'b0, a} + {1'b0, b};
                sum  = t[63:0];
                cout = t[64];
            end
        end else begin
            if (s) begin
                sum  = {32'd0, a[31:0] - b[31:0]};
                cout = (a[31:0] >= b[31:0]);
            end else begin
                t32  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                sum  = {32'd0, t32[31:0]};
                cout = t32[32];
            end
        end
    endfunction

    // Transaction-level model: busy flag, cycles until the result shows, pending result.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic        m_last = ~RR_FIRST;
    logic        m_id;
    logic [63:0] m_sum;
    logic        m_cout;

    always @(negedge clk) begin : model_blk
        logic [1:0]  exp_ready;
        logic        w;
        logic [63:0] a, b;
        if (reset) begin
            m_busy = 1'b0;
            m_wait = 0;
            m_last = ~RR_FIRST;
            check("rst_ready", 64'(sif.req_ready), 64'd0);
            check("rst_valid", 64'(sif.rsp_valid), 64'd0);
            check("rst_id",    64'(sif.rsp_id),    64'd0);
            check("rst_sum",   sif.rsp_sum,        64'd0);
            check("rst_cout",  64'(sif.rsp_cout),  64'd0);
        end else begin
            if (m_busy && m_wait > 0) m_wait--;
            exp_ready = 2'b00;
            if (!m_busy) begin
                case (sif.req_valid)
                    2'b01:   exp_ready = 2'b01;
                    2'b10:   exp_ready = 2'b10;
                    2'b11:   exp_ready = m_last ? 2'b01 : 2'b10;
                    default: exp_ready = 2'b00;
                endcase
            end
            check("req_ready", 64'(sif.req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(sif.rsp_valid), 64'(m_busy && m_wait == 0));
            if (m_busy && m_wait == 0) begin
                check("rsp_id",   64'(sif.rsp_id),   64'(m_id));
                check("rsp_sum",  sif.rsp_sum,       m_sum);
                check("rsp_cout", 64'(sif.rsp_cout), 64'(m_cout));
                if (sif.rsp_ready) m_busy = 1'b0;
            end else if (exp_ready != 2'b00) begin
                w = exp_ready[1];
                a = w ? sif.req1_a : sif.req0_a;
                b = w ? sif.req1_b : sif.req0_b;
                golden(a, b, sif.req_sub[w], sif.req_dw[w], m_sum, m_cout);
                m_busy = 1'b1;
                m_wait = sif.req_dw[w] ? LAT_DW : LAT_SW;
                m_last = w;
                m_id   = w;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        sif.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One isolated operation with literal expectations and latency check.
    task automatic do_op(input logic who, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic d, input logic [63:0] exp_sum,
                         input logic exp_cout, input string name);
        int acc = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        if (who) begin
            sif.req1_a = a; sif.req1_b = b;
        end else begin
            sif.req0_a = a; sif.req0_b = b;
        end
        sif.req_sub[who] = s;
        sif.req_dw[who]  = d;
        sif.req_valid      = 2'b00;
        sif.req_valid[who] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sif.req_ready[who]) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        check({name, "_accept"}, 64'(got), 64'd1);
        @(posedge clk); #1 sif.req_valid = 2'b00;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sif.rsp_valid) got = 1'b1;
        end
        check({name, "_rsp_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({name, "_latency"}, 64'(cyc - acc), 64'(d ? LAT_DW : LAT_SW));
            check({name, "_sum"},  sif.rsp_sum,        exp_sum);
            check({name, "_cout"}, 64'(sif.rsp_cout),  64'(exp_cout));
            check({name, "_id"},   64'(sif.rsp_id),    64'(who));
        end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom % 5)
            0:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            1:       v = 64'd0;
            2:       v = {32'd0, 32'hFFFF_FFFF};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin : stim
        int          n;
        logic        ids [6];
        logic        id0;
        logic [63:0] sum0;
        bit          got;
        logic [1:0]  acc;

        sif.req_valid = 2'b00;
        sif.req0_a = 64'd0; sif.req0_b = 64'd0;
        sif.req1_a = 64'd0; sif.req1_b = 64'd0;
        sif.req_sub = 2'b00; sif.req_dw = 2'b00;
        sif.rsp_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed single/double-word add and sub with hand-computed results.
        do_op(1'b0, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, "sw_add_wrap");
        do_op(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, "dw_add_carry");
        do_op(1'b0, 64'd5, 64'd7, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 1'b0, "sw_sub_borrow");
        do_op(1'b0, 64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, "sw_sub_pos");
        do_op(1'b1, 64'd0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "dw_sub_borrow");

        // Round-robin alternation with both requesters always valid.
        do_reset();
        @(posedge clk); #1;
        sif.req0_a = rand_operand(); sif.req0_b = rand_operand();
        sif.req1_a = rand_operand(); sif.req1_b = rand_operand();
        sif.req_sub = 2'($urandom); sif.req_dw = 2'($urandom);
        sif.rsp_ready = 1'b1;
        sif.req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 80 && n < 6; i++) begin
            @(negedge clk);
            if (sif.rsp_valid) begin
                ids[n] = sif.rsp_id;
                n++;
            end
        end
        @(posedge clk); #1 sif.req_valid = 2'b00;
        check("rr_count", 64'(n), 64'd6);
        for (int i = 0; i < n; i++) check("rr_id_seq", 64'(ids[i]), 64'(i % 2));
        repeat (6) @(posedge clk);

        // Backpressure: response held while both requesters wait.
        #1;
        sif.rsp_ready = 1'b0;
        sif.req_valid = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sif.rsp_valid) got = 1'b1;
        end
        check("stall_rsp_seen", 64'(got), 64'd1);
        id0  = sif.rsp_id;
        sum0 = sif.rsp_sum;
        check("stall_first_id", 64'(id0), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(sif.rsp_valid), 64'd1);
            check("stall_id",    64'(sif.rsp_id),    64'(id0));
            check("stall_sum",   sif.rsp_sum,        sum0);
            check("stall_ready", 64'(sif.req_ready), 64'd0);
        end
        @(posedge clk); #1 sif.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_next_grant", 64'(sif.req_ready), id0 ? 64'd1 : 64'd2);
        @(posedge clk); #1 sif.req_valid = 2'b00;
        repeat (6) @(posedge clk);

        // Reset while the high pass of a double-word op is in flight.
        #1;
        sif.req1_a = rand_operand(); sif.req1_b = rand_operand();
        sif.req_dw[1] = 1'b1;
        sif.req_valid = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sif.req_ready[1]) got = 1'b1;
        end
        check("hi_rst_accept", 64'(got), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sif.req_valid = 2'b11;
        #1;
        check("hi_rst_ready", 64'(sif.req_ready), 64'd0);
        check("hi_rst_valid", 64'(sif.rsp_valid), 64'd0);
        check("hi_rst_id",    64'(sif.rsp_id),    64'd0);
        check("hi_rst_sum",   sif.rsp_sum,        64'd0);
        check("hi_rst_cout",  64'(sif.rsp_cout),  64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 64'(sif.req_ready), 64'd1);
        @(posedge clk); #1 sif.req_valid = 2'b00;
        repeat (6) @(posedge clk);

        // Randomized traffic with random consumer backpressure.
        acc = 2'b00;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (!sif.req_valid[r] || acc[r]) begin
                    sif.req_valid[r] = ($urandom % 3) != 0;
                    sif.req_sub[r]   = 1'($urandom);
                    sif.req_dw[r]    = 1'($urandom);
                    if (r == 0) begin
                        sif.req0_a = rand_operand(); sif.req0_b = rand_operand();
                    end else begin
                        sif.req1_a = rand_operand(); sif.req1_b = rand_operand();
                    end
                end
            end
            sif.rsp_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc = sif.req_valid & sif.req_ready;
        end
        @(posedge clk); #1;
        sif.req_valid = 2'b00;
        sif.rsp_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
